// File: rtl/wb_slave_mem.sv
// wb_slave_mem
//   Wishbone responder for the ARM-side master. Every request is terminated by
//   one ack pulse after WAIT_STATES wait cycles. The cycle then spends one TURN
//   cycle with ack low before another request is accepted.
//   taga_i=0 selects a local 32-bit word array. taga_i=1 selects the byte-wide
//   SSP port, which has 4-deep TX and RX FIFOs.
//   Build option: define WB_SLAVE_SSP_EN to include the SSP path. Without it,
//   taga_i is ignored and the SSP outputs are tied off.
// Ports
//   clk_i, rst_i        clock, synchronous active-high reset
//   adr_i/dat_i/we_i    word address, write data, write enable
//   stb_i/cyc_i/taga_i  request qualifiers and address tag
//   dat_o/ack_o         registered read data (valid with ack), ack pulse
//   ssp_tx_*            TX FIFO head, popped on valid & ready
//   ssp_rx_*            RX FIFO push port, pushed on valid & ready

`ifdef WB_SLAVE_SSP_EN
// 4-entry byte FIFO. A push and a pop in the same cycle are both accepted
// even when the FIFO is full, so the count is unchanged in that case.
module wb_slave_fifo (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       push,
  input  logic [7:0] din,
  input  logic       pop,
  output logic [7:0] dout,
  output logic       empty,
  output logic       full
);
  logic [7:0] mem_q [4];
  logic [1:0] wr_q, wr_d, rd_q, rd_d;
  logic [2:0] cnt_q, cnt_d;
  logic       do_push, do_pop;

  assign empty   = (cnt_q == 3'd0);
  assign full    = (cnt_q == 3'd4);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem_q[rd_q];

  always_comb begin
    wr_d  = wr_q + {1'b0, do_push};
    rd_d  = rd_q + {1'b0, do_pop};
    cnt_d = cnt_q + {2'b0, do_push} - {2'b0, do_pop};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk_i)
    if (do_push) mem_q[wr_q] <= din;
endmodule
`endif

module wb_slave_mem #(
  parameter int DEPTH_LOG2  = 8,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [25:0] adr_i,
  input  logic [31:0] dat_i,
  output logic [31:0] dat_o,
  input  logic        we_i,
  input  logic        stb_i,
  input  logic        cyc_i,
  input  logic        taga_i,
  output logic        ack_o,
  output logic [7:0]  ssp_tx_data,
  output logic        ssp_tx_valid,
  input  logic        ssp_tx_ready,
  input  logic [7:0]  ssp_rx_data,
  input  logic        ssp_rx_valid,
  output logic        ssp_rx_ready
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_ACK  = 2'd2;
  localparam logic [1:0] S_TURN = 2'd3;
  localparam logic [3:0] WS     = 4'(WAIT_STATES);

  logic [1:0]            state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [DEPTH_LOG2-1:0] idx_q, idx_d;
  logic                  we_q, we_d;
  logic [31:0]           wdat_q, wdat_d;
  logic [31:0]           dat_o_q, dat_o_d;
  logic [31:0]           mem [1<<DEPTH_LOG2];

  logic                  req, enter_ack, stall, mem_we, tag_eff_q;
  logic [DEPTH_LOG2-1:0] cur_idx;
  logic                  cur_we, cur_tag;
  logic [31:0]           rdata;
  logic                  unused_adr;

  assign req   = stb_i & cyc_i;
  assign ack_o = (state_q == S_ACK);
  assign dat_o = dat_o_q;
  assign unused_adr = ^adr_i[25:DEPTH_LOG2];

  // In IDLE the request is still on the bus and has not been latched yet.
  // A zero-wait cycle goes to ACK on the capture edge, so it must decode
  // straight from the inputs.
  assign cur_idx = (state_q == S_IDLE) ? adr_i[DEPTH_LOG2-1:0] : idx_q;
  assign cur_we  = (state_q == S_IDLE) ? we_i : we_q;

`ifdef WB_SLAVE_SSP_EN
  logic [1:0] sel_q, sel_d, cur_sel;
  logic       tag_q, tag_d;
  logic       rx_hit_q, rx_hit_d;
  logic       tx_push, tx_pop, tx_empty, tx_full;
  logic       rx_push, rx_empty, rx_full;
  logic [7:0] tx_head, rx_head;

  assign cur_sel   = (state_q == S_IDLE) ? adr_i[1:0] : sel_q;
  assign cur_tag   = (state_q == S_IDLE) ? taga_i : tag_q;
  assign tag_eff_q = tag_q;
  // A TX data write may only enter ACK when a slot is free. Only this FSM
  // pushes TX, so the slot is still free when the push happens in ACK.
  assign stall     = cur_tag & cur_we & (cur_sel == 2'd0) & tx_full;

  // Pop RX at the end of ACK. dat_o already holds the head, which was
  // captured on entry. Later pushes only append, so the head is unchanged.
  assign tx_push = (state_q == S_ACK) & tag_q & we_q & (sel_q == 2'd0);
  assign tx_pop  = ssp_tx_valid & ssp_tx_ready;
  // A pop in the current cycle frees a slot, so a full RX can still accept.
  assign ssp_rx_ready = ~rx_full | rx_hit_q;
  assign rx_push      = ssp_rx_valid & ssp_rx_ready;
  assign ssp_tx_valid = ~tx_empty;
  assign ssp_tx_data  = tx_empty ? 8'h00 : tx_head;

  wb_slave_fifo u_tx (
    .clk_i(clk_i), .rst_i(rst_i), .push(tx_push), .din(wdat_q[7:0]),
    .pop(tx_pop), .dout(tx_head), .empty(tx_empty), .full(tx_full)
  );
  wb_slave_fifo u_rx (
    .clk_i(clk_i), .rst_i(rst_i), .push(rx_push), .din(ssp_rx_data),
    .pop(rx_hit_q), .dout(rx_head), .empty(rx_empty), .full(rx_full)
  );
`else
  logic unused_ssp;
  assign cur_tag      = 1'b0;
  assign tag_eff_q    = 1'b0;
  assign stall        = 1'b0;
  assign ssp_tx_valid = 1'b0;
  assign ssp_tx_data  = 8'h00;
  assign ssp_rx_ready = 1'b0;
  assign unused_ssp   = ^{taga_i, ssp_tx_ready, ssp_rx_data, ssp_rx_valid};
`endif

  always_comb begin
    rdata = '0;
    if (!cur_we) begin
      if (!cur_tag) rdata = mem[cur_idx];
`ifdef WB_SLAVE_SSP_EN
      else begin
        case (cur_sel)
          2'd0:    rdata = {24'h0, rx_empty ? 8'h00 : rx_head};
          2'd1:    rdata = {30'h0, tx_full, rx_empty};
          default: rdata = '0;
        endcase
      end
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    we_d      = we_q;
    wdat_d    = wdat_q;
    enter_ack = 1'b0;
`ifdef WB_SLAVE_SSP_EN
    sel_d     = sel_q;
    tag_d     = tag_q;
`endif
    case (state_q)
      S_IDLE: if (req) begin
        idx_d  = adr_i[DEPTH_LOG2-1:0];
        we_d   = we_i;
        wdat_d = dat_i;
`ifdef WB_SLAVE_SSP_EN
        sel_d  = adr_i[1:0];
        tag_d  = taga_i;
`endif
        cnt_d  = WS;
        if (WS == 4'd0 && !stall) begin
          state_d   = S_ACK;
          enter_ack = 1'b1;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (!req) begin
          state_d = S_IDLE;
        end else begin
          if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
          // cnt_q stays at 0 while a TX-full stall holds the cycle here.
          if (cnt_q <= 4'd1 && !stall) begin
            state_d   = S_ACK;
            enter_ack = 1'b1;
          end
        end
      end
      S_ACK:   state_d = S_TURN;
      default: state_d = S_IDLE;
    endcase
    dat_o_d = enter_ack ? rdata : 32'h0;
`ifdef WB_SLAVE_SSP_EN
    rx_hit_d = enter_ack & cur_tag & ~cur_we & (cur_sel == 2'd0) & ~rx_empty;
`endif
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      we_q     <= 1'b0;
      wdat_q   <= '0;
      dat_o_q  <= '0;
`ifdef WB_SLAVE_SSP_EN
      sel_q    <= '0;
      tag_q    <= 1'b0;
      rx_hit_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      we_q     <= we_d;
      wdat_q   <= wdat_d;
      dat_o_q  <= dat_o_d;
`ifdef WB_SLAVE_SSP_EN
      sel_q    <= sel_d;
      tag_q    <= tag_d;
      rx_hit_q <= rx_hit_d;
`endif
    end
  end

  // The array is not reset. If reset is asserted during ACK, the write is dropped.
  assign mem_we = (state_q == S_ACK) & we_q & ~tag_eff_q & ~rst_i;
  always_ff @(posedge clk_i)
    if (mem_we) mem[idx_q] <= wdat_q;
endmodule

// File: tb/tb_wb_slave_mem.sv
module tb_wb_slave_mem;
  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, we, stb, cyc, tag, en0, stb0;
  logic [25:0] adr;
  logic [31:0] wdat, dat1, dat0;
  logic        ack1, ack0, txv1, txv0, rxr1, rxr0, tx_rdy, rxv;
  logic [7:0]  txd1, txd0, rxd;

  assign stb0 = stb & en0;

  wb_slave_mem #(.DEPTH_LOG2(8), .WAIT_STATES(1)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .adr_i(adr), .dat_i(wdat), .dat_o(dat1),
    .we_i(we), .stb_i(stb), .cyc_i(cyc), .taga_i(tag), .ack_o(ack1),
    .ssp_tx_data(txd1), .ssp_tx_valid(txv1), .ssp_tx_ready(tx_rdy),
    .ssp_rx_data(rxd), .ssp_rx_valid(rxv), .ssp_rx_ready(rxr1));

  wb_slave_mem #(.DEPTH_LOG2(8), .WAIT_STATES(0)) u_dut0 (
    .clk_i(clk), .rst_i(rst), .adr_i(adr), .dat_i(wdat), .dat_o(dat0),
    .we_i(we), .stb_i(stb0), .cyc_i(cyc), .taga_i(tag), .ack_o(ack0),
    .ssp_tx_data(txd0), .ssp_tx_valid(txv0), .ssp_tx_ready(1'b0),
    .ssp_rx_data(rxd), .ssp_rx_valid(rxv), .ssp_rx_ready(rxr0));

  typedef struct {
    logic        we;
    logic [25:0] adr;
    logic [31:0] dat;
    logic [31:0] exp;
  } vec_t;

  int          chk_cnt = 0, pass_cnt = 0;
  logic [31:0] sb_q[$];

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  task automatic wb_start(bit w, bit t, logic [25:0] a, logic [31:0] d);
    we = w; tag = t; adr = a; wdat = d; stb = 1'b1; cyc = 1'b1;
  endtask

  task automatic wb_drop();
    stb = 1'b0; cyc = 1'b0; we = 1'b0;
  endtask

  // lat counts cycles from the capture edge to the first cycle with ack high.
  task automatic wait_ack(int max, output int lat, output bit got,
                          output logic [31:0] d);
    lat = 0; got = 1'b0; d = '0;
    @(posedge clk);
    for (int i = 1; i <= max; i++) begin
      @(negedge clk);
      if (ack1) begin lat = i; got = 1'b1; d = dat1; break; end
    end
  endtask

  task automatic do_cycle(string name, bit w, bit t, logic [25:0] a,
                          logic [31:0] d, logic [31:0] exp, int lat_exp);
    int lat; bit got; logic [31:0] rd, e;
    if (!w) sb_q.push_back(exp);
    wb_start(w, t, a, d);
    wait_ack(40, lat, got, rd);
    check($sformatf("%s ack", name), {31'b0, got}, 32'd1);
    if (!w) e = sb_q.pop_front();
    if (got) begin
      if (lat_exp >= 0) check($sformatf("%s lat", name), 32'(lat), 32'(lat_exp));
      if (!w) check($sformatf("%s dat", name), rd, e);
    end
    wb_drop();
    @(negedge clk);
    check($sformatf("%s pulse", name), {31'b0, ack1}, 32'd0);
    if (!w) check($sformatf("%s dat_o clr", name), dat1, 32'h0);
    @(negedge clk);
  endtask

  vec_t vt[8];

  initial begin
    int lat; bit got, bad; logic [31:0] rd;
    int n0, n1, last0;
    logic [7:0] exp_tx[4];
    rst = 1'b1; we = 0; stb = 0; cyc = 0; tag = 0; en0 = 0;
    adr = '0; wdat = '0; tx_rdy = 0; rxv = 0; rxd = '0;
    repeat (3) @(negedge clk);
    check("rst ack", {31'b0, ack1}, 32'd0);
    check("rst dat_o", dat1, 32'h0);
    check("rst tx", {23'b0, txv1, txd1}, 32'h0);
`ifdef WB_SLAVE_SSP_EN
    check("rst rx_ready", {31'b0, rxr1}, 32'd1);
`else
    check("rst rx_ready", {31'b0, rxr1}, 32'd0);
`endif
    rst = 1'b0;
    @(negedge clk);

    vt[0] = '{1'b1, 26'h000_0005, 32'hDEAD_BEEF, 32'h0};
    vt[1] = '{1'b1, 26'h000_000A, 32'h1234_5678, 32'h0};
    vt[2] = '{1'b0, 26'h000_0005, 32'h0,         32'hDEAD_BEEF};
    vt[3] = '{1'b1, 26'h100_00FF, 32'hCAFE_F00D, 32'h0};
    vt[4] = '{1'b0, 26'h000_00FF, 32'h0,         32'hCAFE_F00D};
    vt[5] = '{1'b0, 26'h2AA_AA0A, 32'h0,         32'h1234_5678};
    vt[6] = '{1'b1, 26'h000_0105, 32'h0000_0000, 32'h0};
    vt[7] = '{1'b0, 26'h000_0005, 32'h0,         32'h0000_0000};
    for (int i = 0; i < 8; i++)
      do_cycle($sformatf("vec%0d", i), vt[i].we, 1'b0, vt[i].adr, vt[i].dat,
               vt[i].exp, 2);

    // Hold stb through TURN. WS=0 must ack every 3rd cycle and WS=1 every 4th.
    en0 = 1'b1;
    wb_start(1'b0, 1'b0, 26'h5, 32'h0);
    n0 = 0; n1 = 0; last0 = -10; bad = 1'b0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (ack0) begin
        if (n0 > 0 && i - last0 != 3) bad = 1'b1;
        last0 = i; n0++;
      end
      if (ack1) n1++;
    end
    check("b2b ws0 count", 32'(n0), 32'd10);
    check("b2b ws0 spacing", {31'b0, bad}, 32'd0);
    check("b2b ws1 count", 32'(n1), 32'd8);
    wb_drop(); en0 = 1'b0;
    repeat (4) @(negedge clk);

    // Abort: drop stb during WAIT, so there is no ack and no write.
    do_cycle("abort pre", 1'b1, 1'b0, 26'h8, 32'h0000_5555, 32'h0, 2);
    wb_start(1'b1, 1'b0, 26'h8, 32'hAAAA_AAAA);
    @(negedge clk);
    wb_drop();
    bad = 1'b0;
    repeat (4) begin @(negedge clk); if (ack1) bad = 1'b1; end
    check("abort noack", {31'b0, bad}, 32'd0);
    do_cycle("abort rd", 1'b0, 1'b0, 26'h8, 32'h0, 32'h0000_5555, 2);

    // Reset during WAIT of a write to index 7.
    do_cycle("rst pre", 1'b1, 1'b0, 26'h7, 32'h1111_1111, 32'h0, 2);
    wb_start(1'b1, 1'b0, 26'h7, 32'h9999_9999);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    bad = ack1;
    rst = 1'b0; wb_drop();
    repeat (3) begin @(negedge clk); if (ack1) bad = 1'b1; end
    check("rst wait noack", {31'b0, bad}, 32'd0);
    do_cycle("rst rd", 1'b0, 1'b0, 26'h7, 32'h0, 32'h1111_1111, 2);

`ifndef WB_SLAVE_SSP_EN
    do_cycle("tag ign wr", 1'b1, 1'b1, 26'h10, 32'h0BAD_F00D, 32'h0, 2);
    do_cycle("tag ign rd", 1'b0, 1'b0, 26'h10, 32'h0, 32'h0BAD_F00D, 2);
    do_cycle("tag ign rd1", 1'b0, 1'b1, 26'h10, 32'h0, 32'h0BAD_F00D, 2);
    check("tieoff", {22'b0, txv1, rxr1, txd1}, 32'h0);
`else
    // Fill TX with the consumer stalled. The fifth write must wait for a slot.
    do_cycle("tx 11", 1'b1, 1'b1, 26'h0, 32'h11, 32'h0, 2);
    do_cycle("tx 22", 1'b1, 1'b1, 26'h0, 32'h22, 32'h0, 2);
    do_cycle("tx 33", 1'b1, 1'b1, 26'h0, 32'h33, 32'h0, 2);
    do_cycle("tx 44", 1'b1, 1'b1, 26'h0, 32'h44, 32'h0, 2);
    do_cycle("stat full", 1'b0, 1'b1, 26'h1, 32'h0, 32'h3, 2);
    wb_start(1'b1, 1'b1, 26'h0, 32'h55);
    bad = 1'b0;
    repeat (6) begin @(negedge clk); if (ack1) bad = 1'b1; end
    check("tx stall noack", {31'b0, bad}, 32'd0);
    check("tx head 11", {23'b0, txv1, txd1}, 32'h111);
    tx_rdy = 1'b1;
    @(negedge clk);
    tx_rdy = 1'b0;
    wait_ack(20, lat, got, rd);
    check("tx stall ack", {31'b0, got}, 32'd1);
    wb_drop();
    repeat (2) @(negedge clk);
    exp_tx = '{8'h22, 8'h33, 8'h44, 8'h55};
    tx_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("tx order %0d", i), {23'b0, txv1, txd1}, {23'b0, 1'b1, exp_tx[i]});
      @(negedge clk);
    end
    tx_rdy = 1'b0;
    check("tx drained", {23'b0, txv1, txd1}, 32'h0);

    do_cycle("ssp wr2", 1'b1, 1'b1, 26'h2, 32'h77, 32'h0, 2);
    check("ssp wr2 noeff", {31'b0, txv1}, 32'd0);
    do_cycle("ssp rd2", 1'b0, 1'b1, 26'h2, 32'h0, 32'h0, 2);

    rxv = 1'b1; rxd = 8'hA5;
    @(negedge clk); rxd = 8'h5A;
    @(negedge clk); rxv = 1'b0;
    do_cycle("rx a5", 1'b0, 1'b1, 26'h0, 32'h0, 32'h0000_00A5, 2);
    do_cycle("rx 5a", 1'b0, 1'b1, 26'h0, 32'h0, 32'h0000_005A, 2);
    do_cycle("rx empty", 1'b0, 1'b1, 26'h0, 32'h0, 32'h0, 2);
    do_cycle("stat empty", 1'b0, 1'b1, 26'h1, 32'h0, 32'h1, 2);

    // With RX full, a push in the same cycle as a pop keeps the count at 4.
    rxv = 1'b1;
    for (int i = 1; i <= 4; i++) begin rxd = 8'(i); @(negedge clk); end
    rxv = 1'b0;
    check("rx full ready pre", {31'b0, rxr1}, 32'd0);
    rxv = 1'b1; rxd = 8'h05;
    do_cycle("rx full pop", 1'b0, 1'b1, 26'h0, 32'h0, 32'h01, 2);
    rxv = 1'b0;
    check("rx full ready post", {31'b0, rxr1}, 32'd0);
    for (int i = 2; i <= 5; i++)
      do_cycle($sformatf("rx drain %0d", i), 1'b0, 1'b1, 26'h0, 32'h0, 32'(i), 2);
    do_cycle("rx drained", 1'b0, 1'b1, 26'h0, 32'h0, 32'h0, 2);
`endif

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: no finish by %0t", $time);
    $fatal(1);
  end
endmodule
